// File: rtl/display_mode_controller.sv
// Debounced mode/hold sequencing and digit scan for the lab 3 seven-segment path.
// Optional hold feature on btnR is enabled by defining DISPLAY_HOLD_EN.
module display_mode_debounce #(
    parameter int CYCLES = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module display_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int SCAN_CYCLES     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switches_inputs,
    input  logic        btnU,
    input  logic        btnR,
    output logic [1:0]  mode,
    output logic        hold,
    output logic [15:0] display_value,
    output logic        dec_overflow,
    output logic [1:0]  digit_idx,
    output logic [3:0]  an
);
    typedef enum logic [1:0] {
        HEX        = 2'd0,
        DEC        = 2'd1,
        RAW_BIN_LO = 2'd2,
        RAW_BIN_HI = 2'd3
    } mode_t;

    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    mode_t         mode_q;
    logic          up_press;
    logic          hold_q;
    logic [15:0]   value_q;
    logic          ovf_q;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_q;

    display_mode_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk   (clk),
        .reset (reset),
        .raw   (btnU),
        .press (up_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= HEX;
        end else if (up_press) begin
            unique case (mode_q)
                HEX:        mode_q <= DEC;
                DEC:        mode_q <= RAW_BIN_LO;
                RAW_BIN_LO: mode_q <= RAW_BIN_HI;
                RAW_BIN_HI: mode_q <= HEX;
            endcase
        end
    end

`ifdef DISPLAY_HOLD_EN
    logic hold_press;

    display_mode_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_hold (
        .clk   (clk),
        .reset (reset),
        .raw   (btnR),
        .press (hold_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= 1'b0;
        end else if (hold_press) begin
            hold_q <= ~hold_q;
        end
    end
`else
    logic unused_btn_r;

    assign unused_btn_r = btnR;
    assign hold_q       = 1'b0;
`endif

    // Capture still happens on the edge hold rises, so the newest switches are frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (!hold_q) begin
                value_q <= switches_inputs;
            end
            ovf_q <= (mode_q == DEC) && (value_q > 16'd9999);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            digit_q  <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            digit_q  <= digit_q + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        an = ~(4'b0001 << digit_q);
        if (ovf_q) begin
            an = 4'b1111;
        end
    end

    assign mode          = mode_q;
    assign hold          = hold_q;
    assign display_value = value_q;
    assign dec_overflow  = ovf_q;
    assign digit_idx     = digit_q;
endmodule

// File: tb/tb_display_mode_controller.sv
// Directed bench for display_mode_controller: scan, mode wrap, hold, overflow blank,
// glitch rejection, simultaneous buttons and reset during debounce.
module tb_display_mode_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] switches_inputs;
    logic        btnU;
    logic        btnR;
    logic [1:0]  mode;
    logic        hold;
    logic [15:0] display_value;
    logic        dec_overflow;
    logic [1:0]  digit_idx;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    display_mode_controller dut (
        .clk             (clk),
        .reset           (reset),
        .switches_inputs (switches_inputs),
        .btnU            (btnU),
        .btnR            (btnR),
        .mode            (mode),
        .hold            (hold),
        .display_value   (display_value),
        .dec_overflow    (dec_overflow),
        .digit_idx       (digit_idx),
        .an              (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic        ovf;
        logic [3:0]  an_blank;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the selected buttons at a negedge, hold them for width cycles,
    // and report the posedge count at which mode / hold first changed (-1 = never).
    task automatic press(input logic u, input logic r, input int width,
                         output int lat_m, output int lat_h);
        logic [1:0] m0;
        logic       h0;
        @(negedge clk);
        m0    = mode;
        h0    = hold;
        lat_m = -1;
        lat_h = -1;
        btnU  = u;
        btnR  = r;
        for (int i = 1; i <= 160; i++) begin
            @(posedge clk);
            #1;
            if (i == width) begin
                btnU = 1'b0;
                btnR = 1'b0;
            end
            if (lat_m < 0 && mode !== m0) lat_m = i;
            if (lat_h < 0 && hold !== h0) lat_h = i;
        end
        idle(120);
    endtask

    int lm;
    int lh;
    logic [15:0] dv_at_fall;
    logic [1:0]  exp_mode;

    initial begin
        vecs[0] = '{16'd0,     1'b0, 4'b0000};
        vecs[1] = '{16'd9999,  1'b0, 4'b0000};
        vecs[2] = '{16'd10000, 1'b1, 4'b1111};
        vecs[3] = '{16'd16052, 1'b1, 4'b1111};
        vecs[4] = '{16'hFFFF,  1'b1, 4'b1111};
        vecs[5] = '{16'd2047,  1'b0, 4'b0000};
        vecs[6] = '{16'd9998,  1'b0, 4'b0000};

        reset           = 1'b1;
        switches_inputs = 16'd0;
        btnU            = 1'b0;
        btnR            = 1'b0;
        idle(3);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_dv", 32'(display_value), 32'd0);
        chk("rst_ovf", 32'(dec_overflow), 32'd0);
        chk("rst_digit", 32'(digit_idx), 32'd0);
        chk("rst_an", 32'(an), 32'hE);
        reset = 1'b0;

        // digit changes exactly every 1000 cycles
        idle(999);
        chk("scan_pre", 32'(an), 32'hE);
        idle(1);
        chk("scan_d1", 32'(an), 32'hD);
        idle(1000);
        chk("scan_d2", 32'(an), 32'hB);
        idle(1000);
        chk("scan_d3", 32'(an), 32'h7);
        idle(1000);
        chk("scan_wrap", 32'(an), 32'hE);
        chk("scan_mode", 32'(mode), 32'd0);

        // mode wrap
        switches_inputs = 16'd2047;
        exp_mode = 2'd0;
        for (int k = 0; k < 4; k++) begin
            press(1'b1, 1'b0, 100, lm, lh);
            exp_mode = exp_mode + 2'd1;
            chk("wrap_mode", 32'(mode), 32'(exp_mode));
            chk("wrap_lat", 32'(lm), 32'd53);
            chk("wrap_ovf", 32'(dec_overflow), 32'd0);
        end

        // hold
        switches_inputs = 16'hA456;
        idle(3);
        press(1'b0, 1'b1, 100, lm, lh);
`ifdef DISPLAY_HOLD_EN
        chk("hold_on", 32'(hold), 32'd1);
        chk("hold_lat", 32'(lh), 32'd53);
`else
        chk("hold_tied", 32'(hold), 32'd0);
`endif
        chk("hold_dv", 32'(display_value), 32'hA456);
        switches_inputs = 16'd9998;
        idle(3);
`ifdef DISPLAY_HOLD_EN
        chk("hold_frozen", 32'(display_value), 32'hA456);
        @(negedge clk);
        btnR = 1'b1;
        lh = -1;
        dv_at_fall = 16'h0;
        for (int i = 1; i <= 160; i++) begin
            @(posedge clk);
            #1;
            if (i == 100) btnR = 1'b0;
            if (lh < 0 && hold === 1'b0) begin
                lh = i;
                dv_at_fall = display_value;
            end
            if (lh > 0 && i == lh + 1) chk("unhold_dv_next", 32'(display_value), 32'h270E);
        end
        idle(120);
        chk("unhold_lat", 32'(lh), 32'd53);
        chk("unhold_dv_edge", 32'(dv_at_fall), 32'hA456);
`else
        chk("track_dv", 32'(display_value), 32'h270E);
        press(1'b0, 1'b1, 100, lm, lh);
        chk("hold_tied2", 32'(hold), 32'd0);
`endif
        chk("unhold_hold", 32'(hold), 32'd0);

        // overflow blanking in DEC
        press(1'b1, 1'b0, 100, lm, lh);
        chk("dec_mode", 32'(mode), 32'd1);
        for (int k = 0; k < 7; k++) begin
            switches_inputs = vecs[k].sw;
            idle(3);
            chk("tbl_ovf", 32'(dec_overflow), 32'(vecs[k].ovf));
            if (vecs[k].ovf)
                chk("tbl_an_blank", 32'(an), 32'(vecs[k].an_blank));
            else
                chk("tbl_an_scan", 32'($countones(~an)), 32'd1);
        end
        switches_inputs = 16'd16052;
        idle(3);
        chk("ovf_set", 32'(dec_overflow), 32'd1);
        chk("ovf_an", 32'(an), 32'hF);
        press(1'b1, 1'b0, 100, lm, lh);
        chk("ovf_mode2", 32'(mode), 32'd2);
        chk("ovf_clear", 32'(dec_overflow), 32'd0);
        chk("ovf_rescan", 32'($countones(~an)), 32'd1);

        // glitch shorter than debounce
        press(1'b1, 1'b0, 30, lm, lh);
        chk("glitch_lat", 32'(lm), 32'hFFFFFFFF);
        chk("glitch_mode", 32'(mode), 32'd2);

        // simultaneous press
        press(1'b1, 1'b1, 100, lm, lh);
        chk("sim_mode", 32'(mode), 32'd3);
        chk("sim_lat_m", 32'(lm), 32'd53);
`ifdef DISPLAY_HOLD_EN
        chk("sim_lat_h", 32'(lh), 32'd53);
        chk("sim_hold", 32'(hold), 32'd1);
`else
        chk("sim_hold", 32'(hold), 32'd0);
`endif

        // reset during debounce, button held through deassert
        @(negedge clk);
        btnU = 1'b1;
        idle(20);
        reset = 1'b1;
        idle(2);
        chk("mid_rst_mode", 32'(mode), 32'd0);
        chk("mid_rst_hold", 32'(hold), 32'd0);
        chk("mid_rst_an", 32'(an), 32'hE);
        reset = 1'b0;
        lm = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (lm < 0 && mode !== 2'd0) lm = i;
        end
        btnU = 1'b0;
        chk("mid_rst_lat", 32'(lm), 32'd53);
        chk("mid_rst_mode1", 32'(mode), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
